// File: rtl/moto_mover.sv
// moto_mover: steps one motorbike sprite across the screen. Each step erases the sprite at
// the old position, moves x/y by one (saturating at the play-field bounds) and redraws it,
// using a req/ack handshake with the VGA drawer.
// Optional feature: define MOTO_LEVEL_SPEEDUP_EN to add the level_up input, which halves
// the idle interval between steps while it is high.

module moto_mover #(
   parameter int unsigned X_INIT   = 26,
   parameter int unsigned Y_INIT   = 24,
   parameter int unsigned X_MIN    = 26,
   parameter int unsigned X_MAX    = 130,
   parameter int unsigned Y_MIN    = 24,
   parameter int unsigned Y_MAX    = 103,
   parameter int unsigned STEP_DIV = 833333,
   parameter int unsigned V_EVERY  = 2
) (
   input  logic       clock,
   input  logic       resetn,
   input  logic       enable,
   input  logic       freeze,
`ifdef MOTO_LEVEL_SPEEDUP_EN
   input  logic       level_up,
`endif
   input  logic       right,
   input  logic       down,
   input  logic       draw_ack,
   output logic [7:0] x,
   output logic [6:0] y,
   output logic       draw_req,
   output logic       erase,
   output logic       moved
);

   localparam logic [7:0]  XInit    = 8'(X_INIT);
   localparam logic [6:0]  YInit    = 7'(Y_INIT);
   localparam logic [7:0]  XMin     = 8'(X_MIN);
   localparam logic [7:0]  XMax     = 8'(X_MAX);
   localparam logic [6:0]  YMin     = 7'(Y_MIN);
   localparam logic [6:0]  YMax     = 7'(Y_MAX);
   localparam logic [19:0] TermFull = 20'(STEP_DIV - 1);
   localparam logic [15:0] VLast    = 16'(V_EVERY - 1);

   typedef enum logic [1:0] {StIdle, StErase, StUpdate, StDraw} state_e;

   state_e      state_q, state_d;
   logic [19:0] div_cnt_q, div_cnt_d;
   logic [15:0] vstep_cnt_q, vstep_cnt_d;
   logic [7:0]  x_q, x_d;
   logic [6:0]  y_q, y_d;
   logic        moved_q, moved_d;
   logic [19:0] term_cnt;
   logic        count_en;

   assign count_en = enable & ~freeze;

`ifdef MOTO_LEVEL_SPEEDUP_EN
   localparam logic [19:0] TermHalf = 20'((STEP_DIV >> 1) - 1);
   // Terminal count follows level_up every idle cycle.
   always_comb begin
      term_cnt = level_up ? TermHalf : TermFull;
   end
`else
   // Fixed step interval.
   always_comb begin
      term_cnt = TermFull;
   end
`endif

   // Next-state, position update and handshake outputs.
   always_comb begin
      state_d     = state_q;
      div_cnt_d   = div_cnt_q;
      vstep_cnt_d = vstep_cnt_q;
      x_d         = x_q;
      y_d         = y_q;
      moved_d     = 1'b0;
      draw_req    = 1'b0;
      erase       = 1'b0;
      case (state_q)
         StIdle: begin
            if (count_en) begin
               // >= so a shortened terminal count takes effect even if already passed
               if (div_cnt_q >= term_cnt) begin
                  state_d   = StErase;
                  div_cnt_d = '0;
               end else begin
                  div_cnt_d = div_cnt_q + 20'd1;
               end
            end
         end
         StErase: begin
            draw_req = 1'b1;
            erase    = 1'b1;
            if (draw_ack) state_d = StUpdate;
         end
         StUpdate: begin
            // Bounds are checked before the +-1 so the position never wraps.
            if (right) begin
               if (x_q < XMax) x_d = x_q + 8'd1;
            end else begin
               if (x_q > XMin) x_d = x_q - 8'd1;
            end
            if (vstep_cnt_q == VLast) begin
               vstep_cnt_d = '0;
               if (down) begin
                  if (y_q < YMax) y_d = y_q + 7'd1;
               end else begin
                  if (y_q > YMin) y_d = y_q - 7'd1;
               end
            end else begin
               vstep_cnt_d = vstep_cnt_q + 16'd1;
            end
            state_d = StDraw;
         end
         StDraw: begin
            draw_req = 1'b1;
            if (draw_ack) begin
               state_d = StIdle;
               moved_d = 1'b1;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   // State and position registers.
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         state_q     <= StIdle;
         div_cnt_q   <= '0;
         vstep_cnt_q <= '0;
         x_q         <= XInit;
         y_q         <= YInit;
         moved_q     <= 1'b0;
      end else begin
         state_q     <= state_d;
         div_cnt_q   <= div_cnt_d;
         vstep_cnt_q <= vstep_cnt_d;
         x_q         <= x_d;
         y_q         <= y_d;
         moved_q     <= moved_d;
      end
   end

   assign x     = x_q;
   assign y     = y_q;
   assign moved = moved_q;

endmodule

// File: tb/tb_moto_mover.sv
// Self-checking bench for moto_mover. A second instance starts at the right edge
// (X_INIT=130) and shares all inputs, so it moves in lockstep with the first.
// Define MOTO_LEVEL_SPEEDUP_EN for both files to exercise the level_up feature.

module tb_moto_mover;

   localparam int XMinP  = 26;
   localparam int XMaxP  = 130;
   localparam int YMinP  = 24;
   localparam int YMaxP  = 103;
   localparam int VEvery = 2;

   logic clock = 1'b0;
   logic resetn = 1'b0;
   logic enable = 1'b0;
   logic freeze = 1'b0;
`ifdef MOTO_LEVEL_SPEEDUP_EN
   logic level_up = 1'b0;
`endif
   logic right = 1'b0;
   logic down = 1'b0;
   logic draw_ack = 1'b1;

   logic [7:0] x, x2;
   logic [6:0] y, y2;
   logic       draw_req, erase, moved;
   logic       draw_req2, erase2, moved2;

   // reference model state
   logic [7:0] xe, x2e;
   logic [6:0] ye;
   int         steps_done;
   int         n_checks = 0;
   int         n_fail = 0;

   moto_mover #(.STEP_DIV(4), .V_EVERY(VEvery)) dut (
      .clock(clock), .resetn(resetn), .enable(enable), .freeze(freeze),
`ifdef MOTO_LEVEL_SPEEDUP_EN
      .level_up(level_up),
`endif
      .right(right), .down(down), .draw_ack(draw_ack),
      .x(x), .y(y), .draw_req(draw_req), .erase(erase), .moved(moved)
   );

   moto_mover #(.X_INIT(130), .STEP_DIV(4), .V_EVERY(VEvery)) dut2 (
      .clock(clock), .resetn(resetn), .enable(enable), .freeze(freeze),
`ifdef MOTO_LEVEL_SPEEDUP_EN
      .level_up(level_up),
`endif
      .right(right), .down(down), .draw_ack(draw_ack),
      .x(x2), .y(y2), .draw_req(draw_req2), .erase(erase2), .moved(moved2)
   );

   always #5 clock = ~clock;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   function automatic logic [7:0] next_x(input logic [7:0] cur, input logic r);
      int t = int'(cur);
      t = r ? ((t + 1 > XMaxP) ? XMaxP : t + 1) : ((t - 1 < XMinP) ? XMinP : t - 1);
      return 8'(t);
   endfunction

   function automatic logic [6:0] next_y(input logic [6:0] cur, input logic d);
      int t = int'(cur);
      t = d ? ((t + 1 > YMaxP) ? YMaxP : t + 1) : ((t - 1 < YMinP) ? YMinP : t - 1);
      return 7'(t);
   endfunction

   task automatic model_reset();
      xe = 8'd26;
      x2e = 8'd130;
      ye = 7'd24;
      steps_done = 0;
   endtask

   // Counts idle samples until the erase request appears.
   task automatic count_to_erase(input int exp_n, input string name);
      int n = 0;
      while (draw_req !== 1'b1 && n < 200) begin
         if (n > 0) begin
            n_checks++;
            if (moved !== 1'b0) begin
               n_fail++;
               $display("FAIL %s moved_in_idle: got %b expected 0", name, moved);
            end
         end
         n++;
         tick();
      end
      n_checks++;
      if (n !== exp_n) begin
         n_fail++;
         $display("FAIL %s idle_cycles: got %0d expected %0d", name, n, exp_n);
      end
   endtask

   // From the first ERASE sample: ed cycles of ack=0, one ack cycle, UPDATE, dd cycles of
   // ack=0 in DRAW, one ack cycle, then the moved sample.
   task automatic finish_step(input int ed, input int dd, input bit frz, input string name);
      for (int i = 0; i <= ed; i++) begin
         if (i == ed) draw_ack = 1'b1;
         n_checks++;
         if ({draw_req, erase, x, y, draw_req2, erase2, x2} !==
             {1'b1, 1'b1, xe, ye, 1'b1, 1'b1, x2e}) begin
            n_fail++;
            $display("FAIL %s erase_phase: got req=%b erase=%b x=%0d y=%0d x2=%0d expected 1 1 %0d %0d %0d",
                     name, draw_req, erase, x, y, x2, xe, ye, x2e);
         end
         tick();
      end
      n_checks++;
      if (draw_req !== 1'b0) begin
         n_fail++;
         $display("FAIL %s update_req: got %b expected 0", name, draw_req);
      end
      xe = next_x(xe, right);
      x2e = next_x(x2e, right);
      steps_done++;
      if (steps_done % VEvery == 0) ye = next_y(ye, down);
      draw_ack = (dd == 0);
      tick();
      for (int i = 0; i <= dd; i++) begin
         if (i == dd) begin
            draw_ack = 1'b1;
            if (frz) freeze = 1'b1;
         end
         n_checks++;
         if ({draw_req, erase, moved, x, y, x2, y2} !==
             {1'b1, 1'b0, 1'b0, xe, ye, x2e, ye}) begin
            n_fail++;
            $display("FAIL %s draw_phase: got req=%b erase=%b moved=%b x=%0d y=%0d x2=%0d y2=%0d expected 1 0 0 %0d %0d %0d %0d",
                     name, draw_req, erase, moved, x, y, x2, y2, xe, ye, x2e, ye);
         end
         tick();
      end
      n_checks++;
      if ({moved, moved2, draw_req} !== 3'b110) begin
         n_fail++;
         $display("FAIL %s moved_pulse: got moved=%b moved2=%b req=%b expected 1 1 0",
                  name, moved, moved2, draw_req);
      end
   endtask

   task automatic step(input int ed, input int dd, input int exp_n, input string name);
      draw_ack = (ed == 0);
      count_to_erase(exp_n, name);
      finish_step(ed, dd, 1'b0, name);
   endtask

   task automatic test_reset();
      enable = 1'b1;
      right = 1'b1;
      down = 1'b1;
      tick();
      tick();
      n_checks++;
      if ({draw_req, erase, moved, x, y, x2} !== {3'b000, 8'd26, 7'd24, 8'd130}) begin
         n_fail++;
         $display("FAIL reset_held: got req=%b erase=%b moved=%b x=%0d y=%0d x2=%0d expected 0 0 0 26 24 130",
                  draw_req, erase, moved, x, y, x2);
      end
      resetn = 1'b1;
      model_reset();
      n_checks++;
      if ({draw_req, erase, moved, x, y} !== {3'b000, 8'd26, 7'd24}) begin
         n_fail++;
         $display("FAIL reset_release: got req=%b erase=%b moved=%b x=%0d y=%0d expected 0 0 0 26 24",
                  draw_req, erase, moved, x, y);
      end
   endtask

   task automatic test_basic();
      step(0, 0, 4, "basic_step1");
      n_checks++;
      if ({x, y} !== {8'd27, 7'd24}) begin
         n_fail++;
         $display("FAIL basic_pos1: got x=%0d y=%0d expected 27 24", x, y);
      end
      step(0, 0, 4, "basic_step2");
      n_checks++;
      if ({x, y} !== {8'd28, 7'd25}) begin
         n_fail++;
         $display("FAIL basic_pos2: got x=%0d y=%0d expected 28 25", x, y);
      end
   endtask

   task automatic test_saturation();
      right = 1'b1;
      step(0, 0, 4, "sat_hold");
      n_checks++;
      if (x2 !== 8'd130) begin
         n_fail++;
         $display("FAIL sat_xmax: got x2=%0d expected 130", x2);
      end
      right = 1'b0;
      step(0, 0, 4, "sat_left");
      n_checks++;
      if (x2 !== 8'd129) begin
         n_fail++;
         $display("FAIL sat_left: got x2=%0d expected 129", x2);
      end
   endtask

   task automatic test_ack_stall();
      right = 1'($urandom);
      down = 1'($urandom);
      step(10, 3, 4, "ack_stall");
   endtask

   task automatic test_freeze();
      right = 1'($urandom);
      down = 1'($urandom);
      draw_ack = 1'b1;
      count_to_erase(4, "freeze_step");
      finish_step(0, 0, 1'b1, "freeze_step");
      for (int i = 0; i < 20; i++) begin
         tick();
         n_checks++;
         if ({draw_req, moved} !== 2'b00) begin
            n_fail++;
            $display("FAIL freeze_hold: got req=%b moved=%b expected 0 0", draw_req, moved);
         end
      end
      freeze = 1'b0;
      enable = 1'b0;
      for (int i = 0; i < 6; i++) begin
         tick();
         n_checks++;
         if (draw_req !== 1'b0) begin
            n_fail++;
            $display("FAIL enable_low_hold: got req=%b expected 0", draw_req);
         end
      end
      enable = 1'b1;
      count_to_erase(4, "unfreeze");
      finish_step(0, 0, 1'b0, "unfreeze");
   endtask

   task automatic test_async_reset();
      right = 1'b1;
      draw_ack = 1'b0;
      count_to_erase(4, "async_rst");
      tick();
      #2;
      resetn = 1'b0;
      #1;
      n_checks++;
      if ({draw_req, erase, x, y, x2} !== {2'b00, 8'd26, 7'd24, 8'd130}) begin
         n_fail++;
         $display("FAIL async_reset: got req=%b erase=%b x=%0d y=%0d x2=%0d expected 0 0 26 24 130",
                  draw_req, erase, x, y, x2);
      end
      tick();
      resetn = 1'b1;
      draw_ack = 1'b1;
      model_reset();
      n_checks++;
      if ({draw_req, moved} !== 2'b00) begin
         n_fail++;
         $display("FAIL async_release: got req=%b moved=%b expected 0 0", draw_req, moved);
      end
      step(0, 0, 4, "after_reset");
   endtask

   task automatic test_speedup();
`ifdef MOTO_LEVEL_SPEEDUP_EN
      level_up = 1'b1;
      step(0, 0, 2, "speedup");
      level_up = 1'b0;
      tick();
      tick();
      // divider now sits past the shortened terminal count
      level_up = 1'b1;
      count_to_erase(1, "speedup_past");
      finish_step(0, 0, 1'b0, "speedup_past");
      level_up = 1'b0;
`else
      step(0, 0, 4, "no_speedup");
`endif
   endtask

   task automatic test_random();
      for (int i = 0; i < 40; i++) begin
         right = 1'($urandom);
         down = 1'($urandom);
         step(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), 4, "random");
      end
   endtask

   initial begin
      model_reset();
      #1;
      test_reset();
      test_basic();
      test_saturation();
      test_ack_stall();
      test_freeze();
      test_async_reset();
      test_speedup();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
